// File: rtl/emisor_handshake.sv
// emisor_handshake: transmit side of a 4-phase req/ack handshake toward an
// asynchronous receiver. Accepts a word via valid/ready, drives it on dato_out
// with req_out, and completes the cycle against a synchronized ack_in.
module emisor_handshake #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] dato_in,
  input  logic              valido_in,
  output logic              listo_out,
  output logic [DATA_W-1:0] dato_out,
  output logic              req_out,
  input  logic              ack_in,
  output logic              hecho,
  output logic              error_to
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      dato_q, dato_d;
  logic                   req_q, req_d;
  logic                   hecho_q, hecho_d;
  logic                   err_q, err_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_sync;
  logic                   accept;
  logic                   timeout_hit;

  // ack_in synchronizer chain; only the last stage is ever used
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ack_in};
    end
  end

  assign ack_sync = sync_q[SYNC_STAGES-1];

  // Ready only in IDLE with the ack released, so a new request never meets a stale ack
  assign listo_out = reset & (state_q == ST_IDLE) & ~ack_sync;
  assign accept    = valido_in & listo_out;

  // Counter reaches its last allowed value; the state exits here so it never wraps
  assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

  // State and registered output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dato_q  <= '0;
      req_q   <= 1'b0;
      hecho_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dato_q  <= dato_d;
      req_q   <= req_d;
      hecho_q <= hecho_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; ack handling takes priority over timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dato_d  = dato_q;
    req_d   = req_q;
    hecho_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dato_d  = dato_in;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_sync) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_REL;
        end else if (timeout_hit) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (TO_EN) begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      ST_REL: begin
        if (!ack_sync) begin
          hecho_d = 1'b1;
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (TO_EN) begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign dato_out = dato_q;
  assign req_out  = req_q;
  assign hecho    = hecho_q;
  assign error_to = err_q;

endmodule
